// File: rtl/atc_uart_pkg.sv
// Shared ATC UART definitions: frame layout, receiver state encoding, default oversampling.
// Imported by the RX block now and intended for the TX block later.
package atc_uart_pkg;

  localparam int FRAME_BITS      = 9;
  localparam int DEF_OVERSAMPLE  = 16;

  // Frame field positions: {plane_id, type, action}
  localparam int ID_MSB     = 8;
  localparam int ID_LSB     = 5;
  localparam int TYPE_MSB   = 4;
  localparam int TYPE_LSB   = 2;
  localparam int ACTION_MSB = 1;
  localparam int ACTION_LSB = 0;

  typedef enum logic [2:0] {
    RXS_IDLE   = 3'd0,
    RXS_START  = 3'd1,
    RXS_DATA   = 3'd2,
    RXS_PARITY = 3'd3,
    RXS_STOP   = 3'd4,
    RXS_BREAK  = 3'd5
  } rx_state_t;

  // Even parity over a frame: the parity bit that makes the total XOR zero.
  function automatic logic even_parity(input logic [FRAME_BITS-1:0] frame);
    return ^frame;
  endfunction

endpackage

// File: rtl/atc_uart_rx_if.sv
// Receiver-side signal bundle: serial line and back-pressure in, frame and status pulses out.
// master = the receiver, slave = the request-FIFO side that consumes frames.
interface atc_uart_rx_if;
  import atc_uart_pkg::*;

  logic                  serial_in;
  logic                  bob_busy;
  logic [FRAME_BITS-1:0] uart_rx_data;
  logic                  uart_rx_valid;
  logic                  framing_error;
  logic                  overrun;
  logic                  parity_error;

  modport master (
    input  serial_in,
    input  bob_busy,
    output uart_rx_data,
    output uart_rx_valid,
    output framing_error,
    output overrun,
    output parity_error
  );

  modport slave (
    output serial_in,
    output bob_busy,
    input  uart_rx_data,
    input  uart_rx_valid,
    input  framing_error,
    input  overrun,
    input  parity_error
  );
endinterface

// File: rtl/atc_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 and pulses tick on DIV-1.
// A synchronous clear restarts the count so the first tick lands DIV cycles later.
module atc_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("atc_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign tick = (count_reg == CW'(DIV - 1));

  always_comb begin
    count_next = count_reg + CW'(1);
    if (clear || tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/atc_uart_rx.sv
// ATC serial receiver: frames 9-bit LSB-first messages and reports valid/overrun/error pulses.
// Optional even parity bit enabled by defining ATC_UART_RX_PARITY_EN.
module atc_uart_rx
  import atc_uart_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9_600,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic          clock,
  input  logic          reset_n,
  atc_uart_rx_if.master rx
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] MID_TICK  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] LAST_TICK = SCW'(OVERSAMPLE - 1);

  localparam logic [2:0] ST_IDLE   = RXS_IDLE;
  localparam logic [2:0] ST_START  = RXS_START;
  localparam logic [2:0] ST_DATA   = RXS_DATA;
  localparam logic [2:0] ST_STOP   = RXS_STOP;
  localparam logic [2:0] ST_BREAK  = RXS_BREAK;
`ifdef ATC_UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = RXS_PARITY;
`endif

  logic [1:0]            sync_reg;
  logic                  line;
  logic                  line_prev_reg;
  logic [2:0]            state_reg, state_next;
  logic [SCW-1:0]        sample_cnt_reg, sample_cnt_next;
  logic [3:0]            bit_idx_reg, bit_idx_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [FRAME_BITS-1:0] data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  ferr_reg, ferr_next;
  logic                  ovr_reg, ovr_next;
  logic                  perr_reg, perr_next;
  logic                  tick;
  logic                  tick_clear;
  logic                  mid_sample;
  logic                  parity_bad;

  atc_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .tick    (tick)
  );

  assign line       = sync_reg[1];
  assign tick_clear = (state_reg == ST_IDLE) && line_prev_reg && !line;
  assign mid_sample = tick && (sample_cnt_reg == MID_TICK);

`ifdef ATC_UART_RX_PARITY_EN
  logic parity_reg, parity_next;
  assign parity_bad = (even_parity(shift_reg) != parity_reg);
`else
  assign parity_bad = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    sample_cnt_next = sample_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    valid_next      = 1'b0;
    ferr_next       = 1'b0;
    ovr_next        = 1'b0;
    perr_next       = 1'b0;
`ifdef ATC_UART_RX_PARITY_EN
    parity_next     = parity_reg;
`endif

    // The sample counter free-wraps once per bit, so every mid-bit sample is OVERSAMPLE ticks apart.
    if (tick) begin
      sample_cnt_next = (sample_cnt_reg == LAST_TICK) ? '0 : sample_cnt_reg + SCW'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (tick_clear) begin
          state_next      = ST_START;
          sample_cnt_next = '0;
        end
      end
      ST_START: begin
        if (mid_sample) begin
          state_next   = line ? ST_IDLE : ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (mid_sample) begin
          shift_next   = {line, shift_reg[FRAME_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 4'd1;
          if (bit_idx_reg == 4'(FRAME_BITS - 1)) begin
`ifdef ATC_UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef ATC_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (mid_sample) begin
          parity_next = line;
          state_next  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop lets a start edge in the second half of the stop bit be caught.
        if (mid_sample) begin
          state_next = ST_IDLE;
          if (!line) begin
            ferr_next  = 1'b1;
            state_next = ST_BREAK;
          end else if (parity_bad) begin
            perr_next = 1'b1;
          end else if (rx.bob_busy) begin
            ovr_next = 1'b1;
          end else begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (line) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg       <= 2'b11;
      line_prev_reg  <= 1'b1;
      state_reg      <= ST_IDLE;
      sample_cnt_reg <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      ferr_reg       <= 1'b0;
      ovr_reg        <= 1'b0;
      perr_reg       <= 1'b0;
`ifdef ATC_UART_RX_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      sync_reg       <= {sync_reg[0], rx.serial_in};
      line_prev_reg  <= line;
      state_reg      <= state_next;
      sample_cnt_reg <= sample_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      ferr_reg       <= ferr_next;
      ovr_reg        <= ovr_next;
      perr_reg       <= perr_next;
`ifdef ATC_UART_RX_PARITY_EN
      parity_reg     <= parity_next;
`endif
    end
  end

  assign rx.uart_rx_data  = data_reg;
  assign rx.uart_rx_valid = valid_reg;
  assign rx.framing_error = ferr_reg;
  assign rx.overrun       = ovr_reg;
  assign rx.parity_error  = perr_reg;

endmodule

// File: tb/tb_atc_uart_rx.sv
// Scoreboard bench for atc_uart_rx: frames are driven bit by bit, expected outcomes queued,
// and a negedge monitor matches every output pulse against the queue.
module tb_atc_uart_rx;
  import atc_uart_pkg::*;

  localparam int BIT_CLKS = 160;
  localparam int K_VALID  = 0;
  localparam int K_FERR   = 1;
  localparam int K_OVR    = 2;
  localparam int K_PERR   = 3;

  typedef struct {
    int         kind;
    logic [8:0] data;
  } ev_t;

  logic clock;
  logic reset_n;
  atc_uart_rx_if rx_bus ();

  ev_t        exp_q[$];
  logic [8:0] last_data;
  int         checks;
  int         errors;

  atc_uart_rx #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rx      (rx_bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n) begin
      int  nset;
      int  kind;
      ev_t e;
      nset = int'(rx_bus.uart_rx_valid) + int'(rx_bus.framing_error)
           + int'(rx_bus.overrun) + int'(rx_bus.parity_error);
      kind = rx_bus.uart_rx_valid ? K_VALID : rx_bus.framing_error ? K_FERR :
             rx_bus.overrun ? K_OVR : K_PERR;
      if (nset > 0) begin
        checks++;
        if (nset > 1) begin
          errors++;
          $display("FAIL multi_pulse: %0d pulses at once, required 1", nset);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: kind=%0d data=%h, required no pulse", kind, rx_bus.uart_rx_data);
        end else begin
          e = exp_q.pop_front();
          if (kind != e.kind || rx_bus.uart_rx_data !== e.data) begin
            errors++;
            $display("FAIL rx_event: kind=%0d data=%h, required kind=%0d data=%h",
                     kind, rx_bus.uart_rx_data, e.kind, e.data);
          end else begin
            $display("rx event kind=%0d data=%h ok", kind, rx_bus.uart_rx_data);
          end
        end
      end
    end
  end

  task automatic drive_line(input logic v, input int n);
    rx_bus.serial_in = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference model: outcome of a completed frame from its stop bit, parity and busy state.
  task automatic expect_frame(input logic [8:0] d, input logic stop_v,
                              input logic par_wrong, input logic busy_v);
    ev_t e;
    if (!stop_v) begin
      e.kind = K_FERR; e.data = last_data;
`ifdef ATC_UART_RX_PARITY_EN
    end else if (par_wrong) begin
      e.kind = K_PERR; e.data = last_data;
`endif
    end else if (busy_v) begin
      e.kind = K_OVR; e.data = last_data;
    end else begin
      e.kind = K_VALID; e.data = d; last_data = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [8:0] d, input logic stop_v, input logic par_wrong,
                            input logic busy_v, input int stop_extra, input int idle_after);
    logic par;
    int   ones;
    ones = 0;
    for (int i = 0; i < 9; i++) ones += int'(d[i]);
    par = ((ones % 2) == 1) ^ par_wrong;
    expect_frame(d, stop_v, par_wrong, busy_v);
    drive_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 9; i++) begin
      rx_bus.bob_busy = 1'($urandom_range(0, 1));
      drive_line(d[i], BIT_CLKS);
    end
`ifdef ATC_UART_RX_PARITY_EN
    drive_line(par, BIT_CLKS);
`else
    if (par === 1'bx) $display("parity bit undefined");
`endif
    rx_bus.bob_busy = busy_v;
    drive_line(stop_v, BIT_CLKS + stop_extra);
    rx_bus.bob_busy = 1'b0;
    if (idle_after > 0) drive_line(1'b1, idle_after);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (rx_bus.uart_rx_data !== 9'h000 || rx_bus.uart_rx_valid !== 1'b0 ||
        rx_bus.framing_error !== 1'b0 || rx_bus.overrun !== 1'b0 || rx_bus.parity_error !== 1'b0) begin
      errors++;
      $display("FAIL %s: data=%h v=%b fe=%b ov=%b pe=%b, required all 0", name,
               rx_bus.uart_rx_data, rx_bus.uart_rx_valid, rx_bus.framing_error,
               rx_bus.overrun, rx_bus.parity_error);
    end else begin
      $display("%s outputs zero ok", name);
    end
  endtask

  initial begin
    logic [8:0] d155;
    checks    = 0;
    errors    = 0;
    last_data = 9'h000;
    reset_n   = 1'b0;
    rx_bus.serial_in = 1'b1;
    rx_bus.bob_busy  = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_idle_outputs("reset_state");
    reset_n = 1'b1;
    drive_line(1'b1, 20);

    // Normal frame
    send_frame(9'h1A5, 1'b1, 1'b0, 1'b0, 0, 40);
    // Start-bit glitch rejected, then normal frame
    drive_line(1'b0, 40);
    drive_line(1'b1, 200);
    send_frame(9'h003, 1'b1, 1'b0, 1'b0, 0, 40);
    // Framing error with line held low, then recovery
    send_frame(9'h0F0, 1'b0, 1'b0, 1'b0, 340, 40);
    send_frame(9'h05A, 1'b1, 1'b0, 1'b0, 0, 40);
    // Overrun: data must stay at the last accepted frame
    send_frame(9'h1FF, 1'b1, 1'b0, 1'b1, 0, 40);
    // Back-to-back frames, no idle gap
    send_frame(9'h001, 1'b1, 1'b0, 1'b0, 0, 0);
    send_frame(9'h100, 1'b1, 1'b0, 1'b0, 0, 40);
`ifdef ATC_UART_RX_PARITY_EN
    send_frame(9'h007, 1'b1, 1'b1, 1'b0, 0, 40);
    send_frame(9'h007, 1'b1, 1'b0, 1'b0, 0, 40);
`endif
    drive_line(1'b1, 300);

    // Reset in the middle of data bit 4
    d155 = 9'h155;
    drive_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_line(d155[i], BIT_CLKS);
    drive_line(d155[4], BIT_CLKS / 2);
    #2;
    reset_n = 1'b0;
    rx_bus.serial_in = 1'b1;
    #1;
    check_idle_outputs("reset_mid_frame");
    last_data = 9'h000;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive_line(1'b1, 2 * BIT_CLKS * 10);
    check_idle_outputs("after_reset_release");
    send_frame(9'h0AA, 1'b1, 1'b0, 1'b0, 0, 40);

    // Randomized frames
    for (int n = 0; n < 16; n++) begin
      logic [8:0] d;
      logic       stop_v;
      logic       busy_v;
      logic       pw;
      int         gap;
      d      = 9'($urandom_range(0, 511));
      stop_v = ($urandom_range(0, 7) != 0);
      busy_v = ($urandom_range(0, 3) == 0);
`ifdef ATC_UART_RX_PARITY_EN
      pw     = ($urandom_range(0, 5) == 0);
`else
      pw     = 1'b0;
`endif
      gap    = stop_v ? int'($urandom_range(0, 1)) * 30 : 40;
      send_frame(d, stop_v, pw, busy_v, stop_v ? 0 : 100, gap);
    end

    // Drain the scoreboard within a bounded wait
    for (int w = 0; w < 3000 && exp_q.size() != 0; w++) @(posedge clock);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse: expected event still queued, required kind=%0d data=%h", e.kind, e.data);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
